bus_terminal_if: RTL and testbench

- RTL terminal interface for one device port of the bs_gnrtr_n_rbtr bus.
- TX side: buffers host packets in a show-ahead FIFO and presents them to the bus through pndng/D_pop/pop.
- RX side: captures packets the bus delivers through push/D_push, checks the destination field against this terminal's ID, and buffers accepted packets for the host.
- One instance is used per bus driver index; it replaces the behavioural driver FIFO model in the testbench.

---
 rtl/bus_terminal_pkg.sv | 27 ++
 rtl/bus_sync_fifo.sv | 56 +++++
 rtl/bus_terminal_if.sv | 109 ++++++++++
 tb/tb_bus_terminal_if.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_terminal_pkg.sv
// Shared types and helpers for the bus terminal interface.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bus_terminal_pkg;

   localparam int ID_W      = 8;
   // Widest packet the destination helper can take; packets are zero-extended to it.
   localparam int MAX_PKT_W = 256;

   localparam logic [ID_W-1:0] BDCST_DEFAULT = 8'hFF;

   typedef logic [15:0] sat_cnt_t;

   // Destination ID lives in the top ID_W bits of a pkt_w-bit packet.
   function automatic logic [ID_W-1:0] get_dest(input logic [MAX_PKT_W-1:0] pkt,
                                                input int pkt_w);
      logic [MAX_PKT_W-1:0] shifted;
      shifted = pkt >> (pkt_w - ID_W);
      return shifted[ID_W-1:0];
   endfunction

   // Event counter that sticks at all-ones instead of wrapping.
   function automatic sat_cnt_t sat_inc(input sat_cnt_t cnt);
      return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
   endfunction

endpackage

// File: rtl/bus_sync_fifo.sv
// Synchronous show-ahead FIFO with wrap-bit pointers.
// Latency: write visible at rd_data/empty one cycle after the write edge.
// Backpressure: write ignored when full unless a read happens in the same cycle.
//
// Ports: clk, reset (sync, active-high); wr_en/wr_data write side;
//        rd_en read side with rd_data showing the head; full, empty, count status.
module bus_sync_fifo #(
   parameter int width = 16,
   parameter int depth = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [width-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [width-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(depth):0]   count
);

   localparam int          AW      = $clog2(depth);
   localparam logic [AW:0] PTR_ONE = 1;

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [width-1:0] mem [depth];
   logic             rd_ok;
   logic             wr_ok;

   // Pointers are equal when empty; they differ only in the wrap bit when full.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign count = wr_ptr - rd_ptr;

   assign rd_ok = rd_en && !empty;
   // A same-cycle read frees the slot, so a full FIFO can still take the write.
   assign wr_ok = wr_en && (!full || rd_ok);

   assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
         if (rd_ok) rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/bus_terminal_if.sv
// Terminal for one bus device port: TX FIFO toward the bus, address-filtered RX FIFO toward the host.
// Latency: host write to pndng 1 cycle; bus push to rx_valid 1 cycle.
// Backpressure: tx_ready deasserts when TX is full; the bus cannot be stalled, so RX overflow drops and counts.
//
// Ports: clk, reset (sync, active-high);
//        host TX: tx_valid, tx_data, tx_ready, tx_count;
//        bus side: pndng, D_pop, pop (TX head out), push, D_push (packet in);
//        host RX: rx_valid, rx_data, rx_ready, rx_count;
//        status: rx_drop_cnt, rx_misroute_cnt (saturating), err_underflow (sticky).
module bus_terminal_if
   import bus_terminal_pkg::*;
#(
   parameter int              pckg_sz = 16,
   parameter int              depth   = 8,
   parameter logic [ID_W-1:0] id      = 8'h00,
   parameter logic [ID_W-1:0] bdcst   = BDCST_DEFAULT
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    tx_valid,
   input  logic [pckg_sz-1:0]      tx_data,
   output logic                    tx_ready,
   output logic                    pndng,
   output logic [pckg_sz-1:0]      D_pop,
   input  logic                    pop,
   input  logic                    push,
   input  logic [pckg_sz-1:0]      D_push,
   output logic                    rx_valid,
   output logic [pckg_sz-1:0]      rx_data,
   input  logic                    rx_ready,
   output logic [$clog2(depth):0]  tx_count,
   output logic [$clog2(depth):0]  rx_count,
   output logic [15:0]             rx_drop_cnt,
   output logic [15:0]             rx_misroute_cnt,
   output logic                    err_underflow
);

   logic            tx_full;
   logic            tx_empty;
   logic            rx_full;
   logic            rx_empty;
   logic [ID_W-1:0] dest;
   logic            addr_match;
   logic            rx_pop;
   logic            rx_wr;
   logic            rx_drop;
   logic            rx_misroute;
   sat_cnt_t        drop_cnt;
   sat_cnt_t        misroute_cnt;
   logic            underflow;

   // ---------------- TX path ----------------
   // tx_ready comes straight from the full flag, so a same-cycle pop on a
   // full FIFO does not open the door to a write.
   assign tx_ready = !tx_full;
   assign pndng    = !tx_empty;

   bus_sync_fifo #(.width(pckg_sz), .depth(depth)) u_tx_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (tx_valid && tx_ready),
      .wr_data (tx_data),
      .rd_en   (pop),
      .rd_data (D_pop),
      .full    (tx_full),
      .empty   (tx_empty),
      .count   (tx_count)
   );

   // ---------------- RX path ----------------
   assign dest        = get_dest(MAX_PKT_W'(D_push), pckg_sz);
   assign addr_match  = (dest == id) || (dest == bdcst);
   assign rx_valid    = !rx_empty;
   assign rx_pop      = rx_valid && rx_ready;
   // A host pop in the same cycle makes room even when the FIFO is full.
   assign rx_wr       = push && addr_match && (!rx_full || rx_pop);
   assign rx_drop     = push && addr_match && rx_full && !rx_pop;
   assign rx_misroute = push && !addr_match;

   bus_sync_fifo #(.width(pckg_sz), .depth(depth)) u_rx_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (rx_wr),
      .wr_data (D_push),
      .rd_en   (rx_ready),
      .rd_data (rx_data),
      .full    (rx_full),
      .empty   (rx_empty),
      .count   (rx_count)
   );

   // ---------------- Status ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         drop_cnt     <= '0;
         misroute_cnt <= '0;
         underflow    <= 1'b0;
      end else begin
         if (rx_drop)       drop_cnt     <= sat_inc(drop_cnt);
         if (rx_misroute)   misroute_cnt <= sat_inc(misroute_cnt);
         if (pop && !pndng) underflow    <= 1'b1;
      end
   end

   assign rx_drop_cnt     = drop_cnt;
   assign rx_misroute_cnt = misroute_cnt;
   assign err_underflow   = underflow;

endmodule

// File: tb/tb_bus_terminal_if.sv
module tb_bus_terminal_if;

   localparam int PW    = 16;
   localparam int DEPTH = 8;
   localparam logic [7:0] MY_ID = 8'h03;

   logic          clk = 1'b0;
   logic          reset;
   logic          tx_valid;
   logic [PW-1:0] tx_data;
   logic          tx_ready;
   logic          pndng;
   logic [PW-1:0] D_pop;
   logic          pop;
   logic          push;
   logic [PW-1:0] D_push;
   logic          rx_valid;
   logic [PW-1:0] rx_data;
   logic          rx_ready;
   logic [3:0]    tx_count;
   logic [3:0]    rx_count;
   logic [15:0]   rx_drop_cnt;
   logic [15:0]   rx_misroute_cnt;
   logic          err_underflow;

   bus_terminal_if #(.pckg_sz(PW), .depth(DEPTH), .id(MY_ID), .bdcst(8'hFF)) dut (
      .clk             (clk),
      .reset           (reset),
      .tx_valid        (tx_valid),
      .tx_data         (tx_data),
      .tx_ready        (tx_ready),
      .pndng           (pndng),
      .D_pop           (D_pop),
      .pop             (pop),
      .push            (push),
      .D_push          (D_push),
      .rx_valid        (rx_valid),
      .rx_data         (rx_data),
      .rx_ready        (rx_ready),
      .tx_count        (tx_count),
      .rx_count        (rx_count),
      .rx_drop_cnt     (rx_drop_cnt),
      .rx_misroute_cnt (rx_misroute_cnt),
      .err_underflow   (err_underflow)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;
   bit chk_en  = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      else
         n_pass++;
   endtask

   // ---------------- Reference model ----------------
   logic [PW-1:0] txq[$];
   logic [PW-1:0] rxq[$];
   int            m_drop = 0;
   int            m_mis  = 0;
   bit            m_err  = 1'b0;

   always @(posedge clk) begin
      if (reset) begin
         txq.delete();
         rxq.delete();
         m_drop = 0;
         m_mis  = 0;
         m_err  = 1'b0;
      end else begin
         bit tx_has, tx_room, rx_has, rx_room, rd;
         tx_has  = txq.size() > 0;
         tx_room = txq.size() < DEPTH;
         rx_has  = rxq.size() > 0;
         rx_room = rxq.size() < DEPTH;
         rd      = rx_ready && rx_has;
         // TX: room is judged before the pop, so a full FIFO refuses the write.
         if (pop && !tx_has) m_err = 1'b1;
         if (pop && tx_has) void'(txq.pop_front());
         if (tx_valid && tx_room) txq.push_back(tx_data);
         // RX
         if (rd) void'(rxq.pop_front());
         if (push) begin
            if (D_push[15:8] == MY_ID || D_push[15:8] == 8'hFF) begin
               if (rx_room || rd) rxq.push_back(D_push);
               else if (m_drop < 65535) m_drop++;
            end else if (m_mis < 65535) begin
               m_mis++;
            end
         end
      end
   end

   // ---------------- Per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         chk("tx_count",  32'(tx_count), 32'(txq.size()));
         chk("pndng",     32'(pndng),    32'(txq.size() > 0));
         chk("tx_ready",  32'(tx_ready), 32'(txq.size() < DEPTH));
         if (txq.size() > 0) chk("D_pop", 32'(D_pop), 32'(txq[0]));
         chk("rx_count",  32'(rx_count), 32'(rxq.size()));
         chk("rx_valid",  32'(rx_valid), 32'(rxq.size() > 0));
         if (rxq.size() > 0) chk("rx_data", 32'(rx_data), 32'(rxq[0]));
         chk("drop_cnt",  32'(rx_drop_cnt),     32'(m_drop));
         chk("mis_cnt",   32'(rx_misroute_cnt), 32'(m_mis));
         chk("underflow", 32'(err_underflow),   32'(m_err));
      end
   end

   // ---------------- Stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle_inputs();
      tx_valid = 1'b0; tx_data = '0; pop = 1'b0;
      push = 1'b0; D_push = '0; rx_ready = 1'b0;
   endtask

   task automatic drain_all();
      idle_inputs();
      for (int k = 0; k < 20 && (txq.size() > 0 || rxq.size() > 0); k++) begin
         pop = 1'b1; rx_ready = 1'b1;
         tick();
      end
      idle_inputs();
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      tick();
      chk_en = 1'b1;
      tick();
      reset = 1'b0;
      tick();

      // Reset/idle state
      chk("idle pndng",    32'(pndng),    32'd0);
      chk("idle rx_valid", 32'(rx_valid), 32'd0);
      chk("idle tx_ready", 32'(tx_ready), 32'd1);
      chk("idle tx_count", 32'(tx_count), 32'd0);

      // Pop on empty TX
      pop = 1'b1; tick(); pop = 1'b0; tick();
      chk("underflow set",  32'(err_underflow), 32'd1);
      chk("underflow cnt0", 32'(tx_count),      32'd0);

      // Three host writes then three pops
      tx_valid = 1'b1; tx_data = 16'h0A01;
      chk("pndng before write", 32'(pndng), 32'd0);
      tick();
      chk("pndng after write", 32'(pndng), 32'd1);
      tx_data = 16'h0A02; tick();
      tx_data = 16'h0A03; tick();
      tx_valid = 1'b0;
      chk("head 1", 32'(D_pop), 32'h0A01);
      pop = 1'b1; tick();
      chk("head 2", 32'(D_pop), 32'h0A02);
      tick();
      chk("head 3", 32'(D_pop), 32'h0A03);
      tick();
      pop = 1'b0;
      chk("tx empty", 32'(pndng), 32'd0);

      // Fill TX, then write+pop while full
      for (int i = 0; i < DEPTH; i++) begin
         tx_valid = 1'b1; tx_data = 16'h0B00 + 16'(i); tick();
      end
      tx_valid = 1'b0;
      chk("full tx_ready", 32'(tx_ready), 32'd0);
      chk("full tx_count", 32'(tx_count), 32'd8);
      tx_valid = 1'b1; tx_data = 16'hDEAD; pop = 1'b1;
      tick();
      tx_valid = 1'b0; pop = 1'b0;
      chk("wr refused count", 32'(tx_count), 32'd7);
      chk("after pop ready",  32'(tx_ready), 32'd1);
      chk("after pop head",   32'(D_pop),    32'h0B01);
      drain_all();

      // RX address filter
      push = 1'b1; D_push = 16'h0312; tick();
      chk("rx own", 32'(rx_data), 32'h0312);
      D_push = 16'hFF55; tick();
      D_push = 16'h0799; tick();
      push = 1'b0;
      chk("misroute cnt", 32'(rx_misroute_cnt), 32'd1);
      chk("rx count 2",   32'(rx_count),        32'd2);
      drain_all();

      // RX overflow and push+pop on full
      for (int i = 0; i < DEPTH; i++) begin
         push = 1'b1; D_push = 16'h0300 + 16'(i); tick();
      end
      D_push = 16'h0308; tick();
      push = 1'b0;
      chk("drop cnt",     32'(rx_drop_cnt), 32'd1);
      chk("rx full cnt",  32'(rx_count),    32'd8);
      push = 1'b1; D_push = 16'h0309; rx_ready = 1'b1; tick();
      push = 1'b0; rx_ready = 1'b0;
      chk("full swap cnt",  32'(rx_count),    32'd8);
      chk("full swap drop", 32'(rx_drop_cnt), 32'd1);
      chk("full swap head", 32'(rx_data),     32'h0301);

      // Randomized traffic
      for (int c = 0; c < 600; c++) begin
         logic [7:0] d;
         case ($urandom_range(0, 3))
            0, 3:    d = MY_ID;
            1:       d = 8'hFF;
            default: d = 8'($urandom);
         endcase
         tx_valid = 1'($urandom_range(0, 1));
         tx_data  = 16'($urandom);
         pop      = ($urandom_range(0, 2) == 0);
         push     = 1'($urandom_range(0, 1));
         D_push   = {d, 8'($urandom)};
         rx_ready = ($urandom_range(0, 2) == 0);
         tick();
      end
      drain_all();

      // Reset in the middle of traffic
      for (int i = 0; i < 5; i++) begin
         tx_valid = 1'b1; tx_data = 16'($urandom); tick();
      end
      tx_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         push = 1'b1; D_push = {MY_ID, 8'(i)}; tick();
      end
      push = 1'b0;
      chk("pre-reset tx", 32'(tx_count), 32'd5);
      chk("pre-reset rx", 32'(rx_count), 32'd4);
      reset = 1'b1;
      tx_valid = 1'b1; pop = 1'b1; push = 1'b1; D_push = 16'h0311; rx_ready = 1'b1;
      tick();
      reset = 1'b0;
      idle_inputs();
      chk("rst tx_count", 32'(tx_count),        32'd0);
      chk("rst rx_count", 32'(rx_count),        32'd0);
      chk("rst pndng",    32'(pndng),           32'd0);
      chk("rst rx_valid", 32'(rx_valid),        32'd0);
      chk("rst drop",     32'(rx_drop_cnt),     32'd0);
      chk("rst mis",      32'(rx_misroute_cnt), 32'd0);
      chk("rst err",      32'(err_underflow),   32'd0);
      tick();
      tick();

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
